freq_meter: RTL

- Gated frequency counter: measures the rate of an external square wave `Sig_In` by counting its rising edges over a fixed gate of `GATE_CYCLES` `CLK_50M` periods (default 1 s).
- Receiving end of the divider path: it measures the divided clocks produced elsewhere in the design and external test signals.
- Results go to the display logic as a binary count, with an optional BCD form.

---
 rtl/freq_meter_pkg.sv | 27 ++
 rtl/freq_meter_bin2bcd_seq.sv | 69 ++++++
 rtl/freq_meter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants for the gated frequency counter; CONV state only exists
// when FREQ_BCD_EN is defined.
package freq_meter_pkg;

  localparam int unsigned BCD_DIGITS      = 8;
  localparam int unsigned BCD_W           = 4 * BCD_DIGITS;
  localparam int unsigned GATE_CYCLES_DEF = 50_000_000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GATE  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
`ifdef FREQ_BCD_EN
  localparam logic [1:0] ST_CONV  = 2'd3;
`endif

  // One double-dabble iteration: add 3 to every digit >= 5, then shift bit_in in.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                   input logic             bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/freq_meter_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (one bit per cycle); only built with
// FREQ_BCD_EN, since nothing instantiates it otherwise.
`ifdef FREQ_BCD_EN
module bin2bcd_seq
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W = 25
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             done_o
);

  localparam int unsigned CW = $clog2(CNT_W + 1);

  logic [CNT_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  // The start cycle already consumes the MSB, so CNT_W-1 further steps follow.
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (start_i) begin
      bcd_d    = dabble_step('0, bin_i[CNT_W-1]);
      bin_d    = bin_i << 1;
      cnt_d    = CW'(1);
      active_d = (CNT_W > 1);
      done_d   = (CNT_W == 1);
    end else if (active_q) begin
      bcd_d = dabble_step(bcd_q, bin_q[CNT_W-1]);
      bin_d = bin_q << 1;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(CNT_W - 1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;

endmodule
`endif

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of Sig_In over
// GATE_CYCLES clocks. FREQ_BCD_EN adds a CONV state and the BCD_Out port.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int unsigned GN          = 26,
  parameter int unsigned CNT_W       = 25
) (
  input  logic             CLK_50M,
  input  logic             CR,
  input  logic             En,
  input  logic             Sig_In,
  output logic [CNT_W-1:0] Freq_Out,
  output logic             Valid,
  output logic             Ovf,
  output logic             Busy
`ifdef FREQ_BCD_EN
  ,
  output logic [BCD_W-1:0] BCD_Out
`endif
);

  localparam logic [GN-1:0]    GATE_LAST = GN'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [GN-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             edge_c;
  logic             finish_c;

  assign edge_c = sync_q[1] & ~sync_q[2];

`ifdef FREQ_BCD_EN
  logic             start_c;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic [BCD_W-1:0] bcd_q, bcd_d;

  assign start_c  = (state_q == ST_LATCH);
  assign finish_c = (state_q == ST_CONV) && conv_done;

  bin2bcd_seq #(.CNT_W(CNT_W)) u_bin2bcd (
    .clk_i  (CLK_50M),
    .rst_i  (CR),
    .start_i(start_c),
    .bin_i  (edge_cnt_q),
    .bcd_o  (conv_bcd),
    .done_o (conv_done)
  );

  assign BCD_Out = bcd_q;
`else
  assign finish_c = (state_q == ST_LATCH);
`endif

  // Next-state and result logic; finish_c publishes the result and re-arms.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
`ifdef FREQ_BCD_EN
    bcd_d      = bcd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (En) begin
          state_d    = ST_GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end
      end
      ST_GATE: begin
        if (!En) begin
          state_d = ST_IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q + GN'(1);
          if (edge_c) begin
            if (edge_cnt_q == CNT_MAX) sat_d = 1'b1;
            else edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
          if (gate_cnt_q == GATE_LAST) state_d = ST_LATCH;
        end
      end
`ifdef FREQ_BCD_EN
      ST_LATCH: state_d = ST_CONV;
      ST_CONV:  state_d = ST_CONV;
`endif
      default:  state_d = ST_IDLE;
    endcase

    if (finish_c) begin
      freq_d  = edge_cnt_q;
      ovf_d   = sat_q;
      valid_d = 1'b1;
`ifdef FREQ_BCD_EN
      bcd_d   = conv_bcd;
`endif
      if (En) begin
        state_d    = ST_GATE;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_50M) begin
    if (CR) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      sync_q     <= '0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FREQ_BCD_EN
      bcd_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      sync_q     <= {sync_q[1:0], Sig_In};
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
`ifdef FREQ_BCD_EN
      bcd_q      <= bcd_d;
`endif
    end
  end

  assign Freq_Out = freq_q;
  assign Valid    = valid_q;
  assign Ovf      = ovf_q;
  assign Busy     = busy_q;

endmodule
